// File: rtl/seg_display_scheduler_pkg.sv
// Shared definitions for the seven-segment display scheduler.
//   page_e      : encodings of the six displayable 16-bit pages
//   mode_e      : page-selection mode state (manual / auto-rotate)
//   BLANK_SEG   : all segments off (active low)
//   ANODES_OFF  : all digits off (active low)
//   page_word() : maps a page number to its 16-bit slice of the core values
package seg_pkg;

  typedef enum logic [2:0] {
    PAGE_INST_LO = 3'd0,
    PAGE_INST_HI = 3'd1,
    PAGE_ALU_LO  = 3'd2,
    PAGE_ALU_HI  = 3'd3,
    PAGE_PC_LO   = 3'd4,
    PAGE_PC_HI   = 3'd5
  } page_e;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  localparam int         NUM_PAGES  = 6;
  localparam logic [6:0] BLANK_SEG  = 7'h7F;
  localparam logic [3:0] ANODES_OFF = 4'hF;

  function automatic logic [15:0] page_word(input logic [2:0]  page,
                                            input logic [31:0] inst,
                                            input logic [31:0] alu,
                                            input logic [31:0] pc);
    logic [15:0] word;
    case (page)
      PAGE_INST_LO: word = inst[15:0];
      PAGE_INST_HI: word = inst[31:16];
      PAGE_ALU_LO:  word = alu[15:0];
      PAGE_ALU_HI:  word = alu[31:16];
      PAGE_PC_LO:   word = pc[15:0];
      PAGE_PC_HI:   word = pc[31:16];
      default:      word = 16'h0000;  // pages 6/7 are never committed
    endcase
    return word;
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Signal bundle between the core-side observer and the display scheduler.
//   master : drives inst/alu_in/pc_in/auto_mode/page_sel/freeze, observes display outputs
//   slave  : the scheduler; consumes the inputs, drives cur_page/frame_tick/enable/LED_out/mode_dbg
// Handshake: there is no valid/ready pair. All inputs are level signals that the
// scheduler samples only on the frame-boundary cycle; all outputs are registered levels,
// except frame_tick, which is a one-cycle registered pulse.
interface seg_display_scheduler_if;
  import seg_pkg::*;

  logic [31:0] inst;
  logic [31:0] alu_in;
  logic [31:0] pc_in;
  logic        auto_mode;
  logic [2:0]  page_sel;
  logic        freeze;
  logic [2:0]  cur_page;
  logic        frame_tick;
  logic [3:0]  enable;
  logic [6:0]  LED_out;
  mode_e       mode_dbg;

  modport master (
    output inst, alu_in, pc_in, auto_mode, page_sel, freeze,
    input  cur_page, frame_tick, enable, LED_out, mode_dbg
  );

  modport slave (
    input  inst, alu_in, pc_in, auto_mode, page_sel, freeze,
    output cur_page, frame_tick, enable, LED_out, mode_dbg
  );
endinterface

// File: rtl/seg_display_scheduler_hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder.
//   i_nibble : 4-bit hex value
//   o_seg    : segments {a,b,c,d,e,f,g}, active low
module hex_to_seg7 (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    case (i_nibble)
      4'h0: o_seg = 7'b0000001;
      4'h1: o_seg = 7'b1001111;
      4'h2: o_seg = 7'b0010010;
      4'h3: o_seg = 7'b0000110;
      4'h4: o_seg = 7'b1001100;
      4'h5: o_seg = 7'b0100100;
      4'h6: o_seg = 7'b0100000;
      4'h7: o_seg = 7'b0001111;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0000100;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b1100000;
      4'hC: o_seg = 7'b0110001;
      4'hD: o_seg = 7'b1000010;
      4'hE: o_seg = 7'b0110000;
      4'hF: o_seg = 7'b0111000;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares the 4-digit seven-segment display between instruction, ALU result
// and PC pages. A page and its 16-bit snapshot are committed only at frame
// boundaries, so digits never change mid-frame. Each digit slot ends with a
// blanking gap to suppress ghosting.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : seg_display_scheduler_if.slave (inputs, display outputs, mode_dbg)
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 400000,
  parameter int BLANK_CYC    = 2000,
  parameter int DWELL_FRAMES = 256
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  seg_display_scheduler_if.slave  bus
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST   = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_START = SW'(SCAN_DIV - BLANK_CYC);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL_FRAMES - 1);

  logic [SW-1:0] r_slot, w_slot_next;
  logic [1:0]    r_digit, w_digit_next;
  logic [DW-1:0] r_dwell, w_dwell_next, w_dwell_cur;
  logic [2:0]    r_page, w_page_next;
  logic [15:0]   r_snap, w_snap_next;
  mode_e         r_mode, w_mode_next;
  logic [3:0]    r_enable;
  logic [6:0]    r_led;
  logic          r_tick;

  logic          w_wrap, w_frame_end, w_blank, w_tick_next;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg;

  hex_to_seg7 u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Output registers are loaded from the *next* counter/snapshot values so that
  // enable/LED_out/frame_tick line up with the slot counter they describe.
  always_comb begin
    w_wrap       = (r_slot == SLOT_LAST);
    w_frame_end  = w_wrap && (r_digit == 2'd3);
    w_slot_next  = w_wrap ? '0 : r_slot + 1'b1;
    w_digit_next = w_wrap ? r_digit + 2'd1 : r_digit;
    w_mode_next  = bus.auto_mode ? MODE_AUTO : MODE_MANUAL;
    // Entering auto from manual starts the dwell from zero on the current page.
    w_dwell_cur  = (r_mode == MODE_AUTO) ? r_dwell : '0;
    w_dwell_next = (w_mode_next == MODE_AUTO) ? w_dwell_cur : '0;
    w_page_next  = r_page;
    w_snap_next  = r_snap;

    if (w_frame_end && !bus.freeze) begin
      if (w_mode_next == MODE_AUTO) begin
        if (w_dwell_cur == DWELL_LAST) begin
          w_dwell_next = '0;
          w_page_next  = (r_page == PAGE_PC_HI) ? 3'(PAGE_INST_LO) : r_page + 3'd1;
        end else begin
          w_dwell_next = w_dwell_cur + 1'b1;
        end
      end else if (bus.page_sel <= PAGE_PC_HI) begin
        w_page_next = bus.page_sel;
      end
      w_snap_next = page_word(w_page_next, bus.inst, bus.alu_in, bus.pc_in);
    end

    w_nibble    = w_snap_next[{w_digit_next, 2'b00} +: 4];
    w_blank     = (w_slot_next >= BLANK_START);
    w_tick_next = (w_slot_next == SLOT_LAST) && (w_digit_next == 2'd3);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_slot   <= '0;
      r_digit  <= 2'd0;
      r_dwell  <= '0;
      r_page   <= PAGE_INST_LO;
      r_snap   <= 16'h0000;
      r_mode   <= MODE_MANUAL;
      r_enable <= ANODES_OFF;
      r_led    <= BLANK_SEG;
      r_tick   <= 1'b0;
    end else begin
      r_slot   <= w_slot_next;
      r_digit  <= w_digit_next;
      r_dwell  <= w_dwell_next;
      r_page   <= w_page_next;
      r_snap   <= w_snap_next;
      r_mode   <= w_mode_next;
      r_enable <= w_blank ? ANODES_OFF : ~(4'b0001 << w_digit_next);
      r_led    <= w_blank ? BLANK_SEG : w_seg;
      r_tick   <= w_tick_next;
    end
  end

  assign bus.cur_page   = r_page;
  assign bus.frame_tick = r_tick;
  assign bus.enable     = r_enable;
  assign bus.LED_out    = r_led;
  assign bus.mode_dbg   = r_mode;
endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;
  import seg_pkg::*;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int DWELL_FRAMES = 2;
  localparam int FRAME_CYC    = 4 * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic Clk;
  logic Rst_n;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  seg_display_scheduler_if bus ();

  seg_display_scheduler #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .DWELL_FRAMES (DWELL_FRAMES)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  // entry = {cur_page, frame_tick, enable, LED_out}
  logic [14:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Expected outputs k cycles into a frame (k=0 is the first cycle of digit 0).
  function automatic logic [14:0] exp_entry(input logic [15:0] word, input logic [2:0] page,
                                            input int k);
    int s;
    int d;
    logic       blank;
    logic       tick;
    logic [3:0] en;
    logic [6:0] led;
    logic [3:0] nib;
    s     = k % SCAN_DIV;
    d     = k / SCAN_DIV;
    blank = (s >= SCAN_DIV - BLANK_CYC);
    tick  = (k == FRAME_CYC - 1);
    nib   = word[4*d +: 4];
    en    = blank ? 4'hF : ~(4'b0001 << d);
    led   = blank ? 7'h7F : seg_tab[nib];
    return {page, tick, en, led};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at the negedge of a frame_tick cycle (or of the reset-release cycle
  // with first_k=1); returns at the negedge of the next frame_tick cycle.
  task automatic run_frame(input logic [15:0] word, input logic [2:0] page,
                           input int first_k, input bit wiggle);
    logic [14:0] obs;
    logic [14:0] exp;
    for (int k = first_k; k < FRAME_CYC; k++) exp_q.push_back(exp_entry(word, page, k));
    for (int k = first_k; k < FRAME_CYC; k++) begin
      @(negedge Clk);
      obs = {bus.cur_page, bus.frame_tick, bus.enable, bus.LED_out};
      exp = exp_q.pop_front();
      tests++;
      assert (obs === exp) else begin
        fails++;
        $error("FAIL frame page%0d k=%0d observed=%h expected=%h", page, k, obs, exp);
      end
      if (wiggle) begin
        bus.inst   = $urandom;
        bus.alu_in = $urandom;
        bus.pc_in  = $urandom;
      end
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_enable"}, 32'(bus.enable), 32'h0000000F);
    check({tag, "_led"}, 32'(bus.LED_out), 32'h0000007F);
    check({tag, "_page"}, 32'(bus.cur_page), 32'h0);
    check({tag, "_tick"}, 32'(bus.frame_tick), 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Rst_n         = 1'b0;
    bus.inst      = 32'h89EF_5A3C;
    bus.alu_in    = 32'h0000_0000;
    bus.pc_in     = 32'h0000_0000;
    bus.auto_mode = 1'b0;
    bus.page_sel  = 3'd0;
    bus.freeze    = 1'b0;

    repeat (3) @(negedge Clk);
    check_dark("reset");

    Rst_n = 1'b1;
    run_frame(16'h0000, 3'd0, 1, 1'b0);      // first frame: snapshot still zero

    run_frame(16'h5A3C, 3'd0, 0, 1'b0);      // page 0 now sampled

    bus.page_sel = 3'd2;
    bus.alu_in   = 32'h1234_ABCD;
    run_frame(16'hABCD, 3'd2, 0, 1'b0);

    bus.page_sel = 3'd5;
    bus.pc_in    = 32'h9876_5432;
    run_frame(16'h9876, 3'd5, 0, 1'b0);

    bus.page_sel = 3'd7;                     // invalid: page holds, word resampled
    bus.pc_in    = 32'hC0DE_5432;
    run_frame(16'hC0DE, 3'd5, 0, 1'b0);
    bus.page_sel = 3'd6;
    run_frame(16'hC0DE, 3'd5, 0, 1'b0);

    bus.page_sel = 3'd4;
    run_frame(16'h5432, 3'd4, 0, 1'b0);

    bus.auto_mode = 1'b1;                    // rotation from page 4, dwell cleared
    bus.page_sel  = 3'd0;
    run_frame(16'h5432, 3'd4, 0, 1'b0);
    check("mode_dbg_auto", 32'(bus.mode_dbg), 32'(MODE_AUTO));
    run_frame(16'hC0DE, 3'd5, 0, 1'b0);
    run_frame(16'hC0DE, 3'd5, 0, 1'b0);
    run_frame(16'h5A3C, 3'd0, 0, 1'b0);      // 5 wraps to 0
    run_frame(16'h5A3C, 3'd0, 0, 1'b0);      // dwell now at its last value

    bus.freeze = 1'b1;                       // inputs scrambled every cycle
    run_frame(16'h5A3C, 3'd0, 0, 1'b1);
    run_frame(16'h5A3C, 3'd0, 0, 1'b1);
    run_frame(16'h5A3C, 3'd0, 0, 1'b1);

    bus.freeze = 1'b0;                       // held dwell resumes: rotate now
    bus.inst   = 32'h7E57_1111;
    bus.alu_in = 32'h1234_ABCD;
    bus.pc_in  = 32'hC0DE_5432;
    run_frame(16'h7E57, 3'd1, 0, 1'b0);

    bus.auto_mode = 1'b0;
    bus.page_sel  = 3'd3;
    run_frame(16'h1234, 3'd3, 0, 1'b0);
    check("mode_dbg_manual", 32'(bus.mode_dbg), 32'(MODE_MANUAL));

    repeat (2 * SCAN_DIV + 2) @(negedge Clk);  // middle of digit 2
    Rst_n = 1'b0;
    #1;
    check_dark("midreset");
    @(negedge Clk);
    Rst_n = 1'b1;
    run_frame(16'h0000, 3'd0, 1, 1'b0);
    run_frame(16'h1234, 3'd3, 0, 1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
